// File: rtl/dtree_pkg.sv
// Shared widths, node-table entry layout and FSM states for the sequential
// decision-tree evaluator and its comparator.
package dtree_pkg;

  localparam int N_FEAT    = 9;
  localparam int FEAT_W    = 8;
  localparam int N_NODES   = 32;
  localparam int CLASS_W   = 2;
  localparam int MAX_DEPTH = 16;

  localparam int FIDX_W  = $clog2(N_FEAT);
  localparam int NIDX_W  = $clog2(N_NODES);
  localparam int PREC_W  = $clog2(FEAT_W + 1);
  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

  typedef struct packed {
    logic                leaf;
    logic [FIDX_W-1:0]   feat;
    logic [PREC_W-1:0]   prec;
    logic [FEAT_W-1:0]   thr;
    logic [NIDX_W-1:0]   left;
    logic [NIDX_W-1:0]   right;
    logic [CLASS_W-1:0]  cls;
  } node_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WALK,
    ST_DONE
  } state_t;

  // An empty table answers every query immediately with class 0.
  localparam node_t RESET_NODE = node_t'({1'b1, {($bits(node_t) - 1){1'b0}}});

  // The index width can be wider than the table in other configurations,
  // so the bound is checked explicitly with one spare bit of headroom.
  function automatic logic node_in_range(input logic [NIDX_W-1:0] idx);
    return {1'b0, idx} < (NIDX_W + 1)'(N_NODES);
  endfunction

endpackage

// File: rtl/dtree_node_cmp.sv
// Single-node comparator: picks one feature, keeps its top 'prec' bits as an
// unsigned value and tests it against the node threshold.
module dtree_node_cmp
  import dtree_pkg::*;
(
  input  logic [N_FEAT*FEAT_W-1:0] feat_vec,
  input  logic [FIDX_W-1:0]        feat_idx,
  input  logic [PREC_W-1:0]        prec,
  input  logic [FEAT_W-1:0]        thr,
  output logic                     go_left
);

  logic [FEAT_W-1:0] sel;
  logic [PREC_W-1:0] eff_prec;
  logic [PREC_W-1:0] shamt;
  logic [FEAT_W-1:0] trunc;

  // Feature select (out-of-range index reads 0), precision clamp, MSB
  // truncation by right shift (a full-width shift yields 0 for prec=0), compare.
  always_comb begin
    sel = '0;
    for (int k = 0; k < N_FEAT; k++) begin
      if (feat_idx == FIDX_W'(k)) begin
        sel = feat_vec[k*FEAT_W +: FEAT_W];
      end
    end
    eff_prec = (prec > PREC_W'(FEAT_W)) ? PREC_W'(FEAT_W) : prec;
    shamt    = PREC_W'(FEAT_W) - eff_prec;
    trunc    = sel >> shamt;
    go_left  = (trunc <= thr);
  end

endmodule

// File: rtl/dtree_seq_eval.sv
// Programmable sequential decision-tree classifier: walks one node per cycle
// through a writable node table, with valid/ready on both sides.
module dtree_seq_eval
  import dtree_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_FEAT*FEAT_W-1:0] in_feat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CLASS_W-1:0]       out_class,
  output logic [DEPTH_W-1:0]       out_depth,
  output logic                     out_err,
  input  logic                     cfg_we,
  output logic                     cfg_ready,
  input  logic [NIDX_W-1:0]        cfg_addr,
  input  logic                     cfg_leaf,
  input  logic [FIDX_W-1:0]        cfg_feat,
  input  logic [PREC_W-1:0]        cfg_prec,
  input  logic [FEAT_W-1:0]        cfg_thr,
  input  logic [NIDX_W-1:0]        cfg_left,
  input  logic [NIDX_W-1:0]        cfg_right,
  input  logic [CLASS_W-1:0]       cfg_class
);

  node_t                     node_tbl [N_NODES];
  state_t                    state;
  logic [N_FEAT*FEAT_W-1:0]  feat_reg;
  logic [NIDX_W-1:0]         node;
  logic [DEPTH_W-1:0]        depth;
  node_t                     cur;
  logic                      go_left;

  // The entry under evaluation this cycle.
  always_comb begin
    cur = node_tbl[node];
  end

  dtree_node_cmp u_cmp (
    .feat_vec (feat_reg),
    .feat_idx (cur.feat),
    .prec     (cur.prec),
    .thr      (cur.thr),
    .go_left  (go_left)
  );

  // Node table: cleared to leaf/class-0 on reset, written only while idle
  // (cfg_ready mirrors the IDLE state) so a walk always sees a frozen table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_NODES; i++) begin
        node_tbl[i] <= RESET_NODE;
      end
    end else if (cfg_we && cfg_ready && node_in_range(cfg_addr)) begin
      node_tbl[cfg_addr] <= '{leaf:  cfg_leaf,
                              feat:  cfg_feat,
                              prec:  cfg_prec,
                              thr:   cfg_thr,
                              left:  cfg_left,
                              right: cfg_right,
                              cls:   cfg_class};
    end
  end

  // Control FSM with registered handshake and result outputs; results keep
  // their last values outside DONE so the consumer sees no glitching.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      feat_reg  <= '0;
      node      <= '0;
      depth     <= '0;
      in_ready  <= 1'b1;
      cfg_ready <= 1'b1;
      out_valid <= 1'b0;
      out_class <= '0;
      out_depth <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            feat_reg  <= in_feat;
            node      <= '0;
            depth     <= '0;
            in_ready  <= 1'b0;
            cfg_ready <= 1'b0;
            state     <= ST_WALK;
          end
        end
        ST_WALK: begin
          if (!node_in_range(node)) begin
            out_class <= '0;
            out_err   <= 1'b1;
            out_depth <= depth;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else if (cur.leaf) begin
            out_class <= cur.cls;
            out_err   <= 1'b0;
            out_depth <= depth;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else if (depth == DEPTH_W'(MAX_DEPTH)) begin
            out_class <= '0;
            out_err   <= 1'b1;
            out_depth <= depth;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            node  <= go_left ? cur.left : cur.right;
            depth <= depth + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            cfg_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dtree_seq_eval.sv
// Self-checking bench for dtree_seq_eval: directed tree cases plus random
// tables and vectors scored against a plain-arithmetic tree-walk model.
module tb_dtree_seq_eval;
  import dtree_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [N_FEAT*FEAT_W-1:0] in_feat = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic [CLASS_W-1:0]       out_class;
  logic [DEPTH_W-1:0]       out_depth;
  logic                     out_err;
  logic                     cfg_we = 1'b0;
  logic                     cfg_ready;
  logic [NIDX_W-1:0]        cfg_addr = '0;
  logic                     cfg_leaf = 1'b0;
  logic [FIDX_W-1:0]        cfg_feat = '0;
  logic [PREC_W-1:0]        cfg_prec = '0;
  logic [FEAT_W-1:0]        cfg_thr = '0;
  logic [NIDX_W-1:0]        cfg_left = '0;
  logic [NIDX_W-1:0]        cfg_right = '0;
  logic [CLASS_W-1:0]       cfg_class = '0;

  int total = 0;
  int bad   = 0;

  int m_leaf [N_NODES];
  int m_feat [N_NODES];
  int m_prec [N_NODES];
  int m_thr  [N_NODES];
  int m_left [N_NODES];
  int m_right[N_NODES];
  int m_cls  [N_NODES];

  dtree_seq_eval dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_feat   (in_feat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_depth (out_depth),
    .out_err   (out_err),
    .cfg_we    (cfg_we),
    .cfg_ready (cfg_ready),
    .cfg_addr  (cfg_addr),
    .cfg_leaf  (cfg_leaf),
    .cfg_feat  (cfg_feat),
    .cfg_prec  (cfg_prec),
    .cfg_thr   (cfg_thr),
    .cfg_left  (cfg_left),
    .cfg_right (cfg_right),
    .cfg_class (cfg_class)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < N_NODES; i++) begin
      m_leaf[i] = 1; m_feat[i] = 0; m_prec[i] = 0; m_thr[i] = 0;
      m_left[i] = 0; m_right[i] = 0; m_cls[i] = 0;
    end
  endtask

  // Walk the tree the way the classifier is described: take the top 'prec'
  // bits of the chosen feature by integer division and compare.
  function automatic void evalModel(input logic [N_FEAT*FEAT_W-1:0] vec,
                                    output int cls, output int dep, output int err);
    int nd, f, p, s;
    nd = 0; dep = 0; cls = 0; err = 1;
    for (int step = 0; step <= MAX_DEPTH + 1; step++) begin
      if (nd >= N_NODES) begin cls = 0; err = 1; return; end
      if (m_leaf[nd] != 0) begin cls = m_cls[nd]; err = 0; return; end
      if (dep == MAX_DEPTH) begin cls = 0; err = 1; return; end
      f = (m_feat[nd] < N_FEAT) ? int'(vec[m_feat[nd]*FEAT_W +: FEAT_W]) : 0;
      p = (m_prec[nd] > FEAT_W) ? FEAT_W : m_prec[nd];
      s = f / (1 << (FEAT_W - p));
      nd = (s <= m_thr[nd]) ? m_left[nd] : m_right[nd];
      dep++;
    end
  endfunction

  task automatic programNode(input int addr, input int leaf, input int feat, input int prec,
                             input int thr, input int left, input int right, input int cls);
    logic took;
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = NIDX_W'(addr); cfg_leaf = leaf[0];
    cfg_feat = FIDX_W'(feat); cfg_prec = PREC_W'(prec); cfg_thr = FEAT_W'(thr);
    cfg_left = NIDX_W'(left); cfg_right = NIDX_W'(right); cfg_class = CLASS_W'(cls);
    took = cfg_ready;
    @(posedge clk);
    #1 cfg_we = 1'b0;
    if (took) begin
      m_leaf[addr] = leaf; m_feat[addr] = feat; m_prec[addr] = prec; m_thr[addr] = thr;
      m_left[addr] = left; m_right[addr] = right; m_cls[addr] = cls;
    end
  endtask

  task automatic programTestTree();
    programNode(0, 0, 2, 2, 1, 1, 2, 0);
    programNode(1, 0, 6, 2, 1, 3, 4, 0);
    programNode(2, 1, 0, 0, 0, 0, 0, 1);
    programNode(3, 1, 0, 0, 0, 0, 0, 3);
    programNode(4, 1, 0, 0, 0, 0, 0, 2);
  endtask

  task automatic applyStimulus(input logic [N_FEAT*FEAT_W-1:0] vec);
    @(negedge clk);
    in_feat = vec; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic waitResult(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    if (!out_valid) checkOutput("timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic releaseResult();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    checkOutput("valid_drop", 32'(out_valid), 32'd0);
    checkOutput("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  task automatic runAndCheck(input string tag, input logic [N_FEAT*FEAT_W-1:0] vec,
                             input int exp_cls, input int exp_dep, input int exp_err);
    int lat;
    applyStimulus(vec);
    waitResult(lat);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_dep + 1));
    checkOutput({tag, "_class"}, 32'(out_class), 32'(exp_cls));
    checkOutput({tag, "_depth"}, 32'(out_depth), 32'(exp_dep));
    checkOutput({tag, "_err"}, 32'(out_err), 32'(exp_err));
    releaseResult();
  endtask

  function automatic logic [N_FEAT*FEAT_W-1:0] randVec();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[N_FEAT*FEAT_W-1:0];
  endfunction

  initial begin
    logic [N_FEAT*FEAT_W-1:0] vec;
    int c, d, e, lat;

    modelReset();
    $display("[TB] reset state");
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_class", 32'(out_class), 32'd0);
    checkOutput("rst_out_depth", 32'(out_depth), 32'd0);
    checkOutput("rst_out_err", 32'(out_err), 32'd0);

    $display("[TB] reset table inference");
    runAndCheck("rst_table", randVec(), 0, 0, 0);

    $display("[TB] two-level tree");
    programTestTree();
    vec = '0; vec[2*FEAT_W +: FEAT_W] = 8'h40; vec[6*FEAT_W +: FEAT_W] = 8'h80;
    runAndCheck("tree_deep", vec, 2, 2, 0);
    vec = '0; vec[2*FEAT_W +: FEAT_W] = 8'hC0;
    runAndCheck("tree_shallow", vec, 1, 1, 0);
    for (int i = 0; i < 8; i++) begin
      vec = randVec();
      evalModel(vec, c, d, e);
      runAndCheck("tree_rand", vec, c, d, e);
    end

    $display("[TB] random tables");
    for (int t = 0; t < 3; t++) begin
      for (int a = 0; a < N_NODES; a++) begin
        programNode(a, ($urandom_range(0, 2) == 0) ? 1 : 0, $urandom_range(0, 15),
                    $urandom_range(0, 15), $urandom_range(0, 255),
                    $urandom_range(0, N_NODES - 1), $urandom_range(0, N_NODES - 1),
                    $urandom_range(0, 3));
      end
      for (int i = 0; i < 10; i++) begin
        vec = randVec();
        evalModel(vec, c, d, e);
        runAndCheck("rand_table", vec, c, d, e);
      end
    end

    $display("[TB] self loop");
    programNode(0, 0, 0, 8, 255, 0, 0, 0);
    runAndCheck("self_loop", randVec(), 0, MAX_DEPTH, 1);

    $display("[TB] same-cycle write and accept");
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = '0; cfg_leaf = 1'b1; cfg_feat = '0; cfg_prec = '0;
    cfg_thr = '0; cfg_left = '0; cfg_right = '0; cfg_class = 2'd3;
    in_feat = randVec(); in_valid = 1'b1;
    @(posedge clk);
    #1 begin cfg_we = 1'b0; in_valid = 1'b0; end
    m_leaf[0] = 1; m_cls[0] = 3;
    waitResult(lat);
    checkOutput("same_cycle_latency", 32'(lat), 32'd1);
    checkOutput("same_cycle_class", 32'(out_class), 32'd3);
    releaseResult();

    $display("[TB] hold in DONE");
    programTestTree();
    vec = '0; vec[2*FEAT_W +: FEAT_W] = 8'h40; vec[6*FEAT_W +: FEAT_W] = 8'h80;
    applyStimulus(vec);
    waitResult(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = '0; cfg_leaf = 1'b1; cfg_class = 2'd3;
      @(posedge clk);
      #1;
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_class", 32'(out_class), 32'd2);
      checkOutput("hold_depth", 32'(out_depth), 32'd2);
      checkOutput("hold_err", 32'(out_err), 32'd0);
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
      checkOutput("hold_cfg_ready", 32'(cfg_ready), 32'd0);
    end
    cfg_we = 1'b0;
    releaseResult();
    runAndCheck("readback", vec, 2, 2, 0);

    $display("[TB] reset during walk");
    programNode(0, 0, 0, 8, 255, 0, 0, 0);
    applyStimulus(randVec());
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1 checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    @(negedge clk) rst = 1'b0;
    modelReset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 checkOutput("midrst_no_valid", 32'(out_valid), 32'd0);
    end
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    vec = randVec();
    evalModel(vec, c, d, e);
    runAndCheck("post_rst", vec, c, d, e);
    runAndCheck("post_rst_leaf0", randVec(), 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dtree_seq_eval.md
Name: dtree_seq_eval

Overview:
- Programmable, sequential decision-tree classifier. It is the parametrised successor to the team's fixed combinational per-dataset tree modules.
- The node table sits in a writable register array, so one instance serves any tree that fits N_NODES and MAX_DEPTH.
- Each cycle it evaluates one node and accepts one feature vector per inference through a valid/ready handshake.
- It sits between the sensor/feature front end and the class-result consumer.

Parameters:
- N_FEAT, 9, number of input features.
- FEAT_W, 8, bits per feature.
- N_NODES, 32, node-table entries; the root is always entry 0.
- CLASS_W, 2, width of the class label.
- MAX_DEPTH, 16, maximum number of compare steps before the walk aborts with an error.
- Derived, in the package: FIDX_W = clog2(N_FEAT), NIDX_W = clog2(N_NODES), PREC_W = clog2(FEAT_W+1), DEPTH_W = clog2(MAX_DEPTH+1).

Ports:
- clk in 1: sole clock.
- rst in 1: asynchronous, active-high reset.
- in_valid in 1: feature vector valid.
- in_ready out 1: block can accept a vector.
- in_feat in N_FEAT*FEAT_W: packed features; feature k occupies bits [k*FEAT_W +: FEAT_W].
- out_valid out 1: result valid.
- out_ready in 1: consumer accepts the result.
- out_class out CLASS_W: predicted class.
- out_depth out DEPTH_W: number of compare steps taken.
- out_err out 1: walk aborted.
- cfg_we in 1: node write strobe.
- cfg_ready out 1: high only in IDLE.
- cfg_addr in NIDX_W: node index.
- cfg_leaf in 1: entry is a leaf.
- cfg_feat in FIDX_W: feature index.
- cfg_prec in PREC_W: number of feature MSBs compared.
- cfg_thr in FEAT_W: threshold.
- cfg_left in NIDX_W: next node when the compare is true.
- cfg_right in NIDX_W: next node when the compare is false.
- cfg_class in CLASS_W: leaf label.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - Every node entry becomes a leaf with class 0 and all other fields 0.
  - out_valid=0, out_class=0, out_depth=0, out_err=0.
  - in_ready=1 and cfg_ready=1 once rst deasserts.
  - Reset mid-walk discards the inference with no output.
- Config:
  - A write takes effect on a clk edge where cfg_we && cfg_ready.
  - cfg_we outside IDLE is ignored. The table is never modified mid-walk.
  - cfg_addr >= N_NODES is ignored.
  - A same-cycle cfg_we and in_valid handshake in IDLE is legal: the write completes and the walk starts using the updated table.
- States: IDLE, WALK, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_feat, set node=0, depth=0, and go to WALK.
- WALK (in_ready=0): one node per cycle.
  - If node >= N_NODES: go to DONE with err=1, class=0.
  - Else if the entry is a leaf: class=entry class, err=0, go to DONE.
  - Else if depth == MAX_DEPTH: go to DONE with err=1, class=0.
  - Otherwise compare s <= thr, where s is the top cfg_prec bits of feature feat, zero-extended to FEAT_W.
    - prec=0 gives s=0.
    - prec>FEAT_W is clamped to FEAT_W.
    - feat >= N_FEAT reads 0.
    - The next node is left on true, right on false; depth increments.
- DONE:
  - out_valid=1, with out_class, out_depth and out_err held stable.
  - On out_ready, go to IDLE. The next vector can be accepted on the following cycle; there is no same-cycle bypass.
  - out_valid must not drop without out_ready.
- Latency: the walk begins at the accept edge, and a leaf at depth d asserts out_valid d+1 cycles after that edge. Throughput is one inference per (d+3) cycles, including the IDLE cycle.
- Outputs are registered, and outputs stay at their last values while in IDLE and WALK.

Decomposition:
- Package dtree_pkg holds:
  - the derived widths;
  - the node_t packed struct {leaf, feat, prec, thr, left, right, cls};
  - the state enum;
  - the reset-node constant (leaf=1, all else 0).
- One sub-module, dtree_node_cmp: combinational feature select, MSB truncation and <= compare, returning go_left. It is reused by future parallel-lane variants.

Test Plan:
- Reset table, feed any vector -> out_valid 1 cycle after accept, class 0, depth 0, err 0.
- Program the two-level tree below, feed X2=0x40 and X6=0x80 -> class 2, depth 2, out_valid 3 cycles after accept.
  - node0: feat 2, prec 2, thr 1, left 1, right 2.
  - node1: feat 6, prec 2, thr 1, left 3, right 4.
  - node2: leaf, class 1.
  - node3: leaf, class 3.
  - node4: leaf, class 2.
- Same tree, X2=0xC0 -> class 1, depth 1.
- Self-loop node0 (left=0, right=0, non-leaf) -> err 1, class 0, depth=MAX_DEPTH.
- Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, cfg_we ignored (a readback inference afterwards shows the table unchanged).
- Assert rst during WALK -> no out_valid; next inference runs on the reset (leaf-0) table.
